// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the MIPS32 execute stage.
// Multiply is radix-2 shift-add and divide is restoring, one bit per cycle in
// both cases. Magnitudes are used internally and the signs are applied in FIX.
// Optional feature macro: MULDIV_DIV_EN. When it is defined the divider is built.
// When it is undefined, DIV/DIVU take a one-cycle IDLE->FIX path and leave HI/LO
// unchanged.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Two's-complement negation of an N-bit word.
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a 2N-bit word.
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
    return ~x + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  // Absolute value when the operation is signed. |most-negative| wraps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [N-1:0] mag_n(input logic [N-1:0] x, input logic sgn);
    return (sgn && x[N-1]) ? neg_n(x) : x;
  endfunction

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           neg_lo_q, neg_lo_d;   // sign applied to product / quotient
  logic [N-1:0]   opnd_q, opnd_d;       // |multiplicand| or |divisor|
  logic [2*N-1:0] acc_q, acc_d;         // product accumulator; low half holds the quotient
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           signed_op_s;
  logic [N-1:0]   mag_a_s;
  logic [N-1:0]   mag_b_s;
  logic [N:0]     mul_sum_s;
  logic [2*N-1:0] prod_s;
`ifdef MULDIV_DIV_EN
  logic           neg_hi_q, neg_hi_d;   // sign applied to remainder
  logic           div0_q, div0_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N:0]     shifted_s;            // 33-bit partial remainder before the trial subtract
  logic           ge_s;
  logic [N-1:0]   diff_s;
  logic [N-1:0]   quo_fix_s;
  logic [N-1:0]   rem_fix_s;
`endif

  // Datapath: operand magnitudes, one shift-add/restore step, final sign fix.
  always_comb begin
    signed_op_s = ~op[0];
    mag_a_s     = mag_n(inA, signed_op_s);
    mag_b_s     = mag_n(inB, signed_op_s);
    mul_sum_s   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    prod_s      = neg_lo_q ? neg_2n(acc_q) : acc_q;
`ifdef MULDIV_DIV_EN
    shifted_s   = {rem_q, acc_q[N-1]};
    ge_s        = (shifted_s >= {1'b0, opnd_q});
    diff_s      = shifted_s[N-1:0] - opnd_q;
    quo_fix_s   = neg_lo_q ? neg_n(acc_q[N-1:0]) : acc_q[N-1:0];
    rem_fix_s   = neg_hi_q ? neg_n(rem_q) : rem_q;
`endif
  end

  // Control FSM next-state logic and register next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    rem_d    = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = inA;
            OP_MTLO: lo_d = inA;
            OP_MULT, OP_MULTU: begin
              opnd_d   = mag_a_s;
              acc_d    = {{N{1'b0}}, mag_b_s};
              neg_lo_d = signed_op_s & (inA[N-1] ^ inB[N-1]);
              is_div_d = 1'b0;
              cnt_d    = 5'd0;
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              opnd_d   = mag_b_s;
              acc_d    = {{N{1'b0}}, mag_a_s};
              rem_d    = {N{1'b0}};
              neg_lo_d = signed_op_s & (inA[N-1] ^ inB[N-1]);
              neg_hi_d = signed_op_s & inA[N-1];
              div0_d   = (inB == {N{1'b0}});
              is_div_d = 1'b1;
              cnt_d    = 5'd0;
              state_d  = S_RUN;
`else
              is_div_d = 1'b1;
              state_d  = S_FIX;
`endif
            end
            default: ;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          rem_d = ge_s ? diff_s : shifted_s[N-1:0];
          acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], ge_s};
        end else begin
          acc_d = {mul_sum_s, acc_q[N-1:1]};
        end
`else
        acc_d = {mul_sum_s, acc_q[N-1:1]};
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
          hi_d = rem_fix_s;
          lo_d = div0_q ? {N{1'b1}} : quo_fix_s;
`endif
        end else begin
          hi_d = prod_s[2*N-1:N];
          lo_d = prod_s[N-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      opnd_q   <= {N{1'b0}};
      acc_q    <= {(2*N){1'b0}};
      hi_q     <= {N{1'b0}};
      lo_q     <= {N{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      rem_q    <= {N{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO plus the
// cycle it must appear; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  muldiv_unit #(.N(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .inA(inA), .inB(inB), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Edge counter used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int sa, sb;
    logic [63:0] r;
    r = 64'h0;
    case (o)
      3'd0: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        r  = pa * pb;
      end
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          sa = a;
          sb = b;
          r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      3'd3: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // Issue one request from IDLE and record what the DUT must produce.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard;
    int t0;
    logic [63:0] r;
    logic [31:0] prev_hi, prev_lo;
    exp_t e;
    guard = 0;
    while (busy !== 1'b0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("wait_idle", 64'(busy), 64'h0);
    prev_hi = model_hi;
    prev_lo = model_lo;
    start = 1'b1; op = o; inA = a; inB = b;
    t0 = cyc + 1;
    case (o)
      3'd0, 3'd1: begin
        r = ref_model(o, a, b);
        model_hi = r[63:32]; model_lo = r[31:0];
        e.hi = model_hi; e.lo = model_lo; e.due = t0 + 33;
        exp_q.push_back(e);
      end
      3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
        r = ref_model(o, a, b);
        model_hi = r[63:32]; model_lo = r[31:0];
        e.due = t0 + 33;
`else
        e.due = t0 + 1;
`endif
        e.hi = model_hi; e.lo = model_lo;
        exp_q.push_back(e);
      end
      3'd4: model_hi = a;
      3'd5: model_lo = a;
      default: ;
    endcase
    @(negedge clock);
    start = 1'b0; op = 3'($urandom); inA = $urandom; inB = $urandom;
    if (o >= 3'd4) begin
      check("move_busy", 64'(busy), 64'h0);
      check("move_hi", 64'(hi), 64'(model_hi));
      check("move_lo", 64'(lo), 64'(model_lo));
    end else begin
      check("run_busy", 64'(busy), 64'h1);
      check("run_hold", {hi, lo}, {prev_hi, prev_lo});
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("drain", 64'(exp_q.size()), 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare each done pulse against the scoreboard head.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'h1, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_hi", 64'(hi), 64'(e.hi));
          check("result_lo", 64'(lo), 64'(e.lo));
          check("latency", 64'(cyc), 64'(e.due));
          check("done_busy", 64'(busy), 64'h0);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        check("done_timeout", 64'(cyc), 64'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got cycle %0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; inA = 32'h0; inB = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_state", {32'(busy), 31'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(3'd3, 32'd100, 32'h0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    // MTHI while busy is dropped; HI keeps its pre-run value.
    begin
      logic [31:0] old_hi;
      old_hi = hi;
      issue(3'd0, 32'h0000_0123, 32'hFFFF_FF00);
      repeat (3) @(negedge clock);
      start = 1'b1; op = 3'd4; inA = 32'h1234;
      @(negedge clock);
      start = 1'b0;
      check("mthi_busy_ignored", 64'(hi), 64'(old_hi));
      drain();
    end
    issue(3'd4, 32'h1234, 32'h0);
    issue(3'd5, 32'hCAFE_0001, 32'h0);
    issue(3'd6, 32'h5555_5555, 32'h0);

    // Reset in the middle of a MULT discards it.
    issue(3'd0, 32'h7654_3210, 32'h0BAD_F00D);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    model_hi = 32'h0;
    model_lo = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    check("midrun_reset_busy", {32'(busy), 31'h0, done}, 64'h0);
    check("midrun_reset_hilo", {hi, lo}, 64'h0);
    issue(3'd1, 32'd3, 32'd5);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    drain();
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
